// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter that hands the single SPI master to one requester per frame.
// Optional watchdog abort of a stuck frame is compiled in with SPI_ARB_TIMEOUT_EN.
module spi_req_arbiter #(
    parameter int N_REQ          = 2,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_i,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_tx_word_i,
    output logic [N_REQ-1:0]            grant_o,
    output logic [N_REQ-1:0]            req_done_o,
    output logic [DATA_WIDTH-1:0]       rx_word_o,
    output logic                        timeout_err_o,
    output logic                        enable_spi_o,
    output logic [DATA_WIDTH-1:0]       tx_byte_spi_o,
    input  logic                        busy_spi_i,
    input  logic                        complete_spi_i,
    input  logic [DATA_WIDTH-1:0]       rx_byte_spi_i
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                 state_q;
    logic [IDX_W-1:0]       rr_ptr_q;
    logic [IDX_W-1:0]       rr_ptr_d;
    logic [IDX_W-1:0]       owner_q;
    logic [N_REQ-1:0]       grant_q;
    logic [N_REQ-1:0]       req_done_q;
    logic [DATA_WIDTH-1:0]  rx_word_q;
    logic [DATA_WIDTH-1:0]  tx_q;
    logic                   enable_q;
    logic                   timeout_err_q;
    logic                   tmo_hit;

    logic [2*N_REQ-1:0]     req_dbl;
    logic                   win_found;
    logic [IDX_W-1:0]       win_off;
    logic [IDX_W:0]         win_sum;
    logic [IDX_W-1:0]       win_idx;
    logic [DATA_WIDTH-1:0]  tx_arr [N_REQ];

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            tx_arr[i] = req_tx_word_i[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Rotate so bit 0 is the requester at rr_ptr, take the lowest set bit,
    // then rotate the offset back into an absolute requester index.
    always_comb begin
        req_dbl   = {req_i, req_i} >> rr_ptr_q;
        win_found = 1'b0;
        win_off   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!win_found && req_dbl[k]) begin
                win_found = 1'b1;
                win_off   = IDX_W'(k);
            end
        end
        win_sum = {1'b0, rr_ptr_q} + {1'b0, win_off};
        if (win_sum >= (IDX_W+1)'(N_REQ)) begin
            win_sum = win_sum - (IDX_W+1)'(N_REQ);
        end
        win_idx = win_sum[IDX_W-1:0];
    end

    assign rr_ptr_d = (owner_q == IDX_W'(N_REQ-1)) ? '0 : owner_q + 1'b1;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt_q;

    // Zero in every non-XFER cycle, so it is already clear on XFER entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
        end else if (state_q == XFER) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end else begin
            tmo_cnt_q <= '0;
        end
    end

    assign tmo_hit = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            owner_q       <= '0;
            grant_q       <= '0;
            req_done_q    <= '0;
            rx_word_q     <= '0;
            tx_q          <= '0;
            enable_q      <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            req_done_q    <= '0;
            timeout_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_found && !busy_spi_i) begin
                        grant_q  <= N_REQ'(1) << win_idx;
                        owner_q  <= win_idx;
                        tx_q     <= tx_arr[win_idx];
                        enable_q <= 1'b1;
                        state_q  <= XFER;
                    end
                end
                XFER: begin
                    if (complete_spi_i) begin
                        rx_word_q  <= rx_byte_spi_i;
                        enable_q   <= 1'b0;
                        req_done_q <= grant_q;
                        state_q    <= DONE;
                    end else if (tmo_hit) begin
                        enable_q      <= 1'b0;
                        req_done_q    <= grant_q;
                        timeout_err_q <= 1'b1;
                        state_q       <= DONE;
                    end
                end
                DONE: begin
                    grant_q  <= '0;
                    rr_ptr_q <= rr_ptr_d;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant_o       = grant_q;
    assign req_done_o    = req_done_q;
    assign rx_word_o     = rx_word_q;
    assign tx_byte_spi_o = tx_q;
    assign enable_spi_o  = enable_q;
    assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Bench for spi_req_arbiter: transaction-level model compared every cycle, directed
// scenarios with literal expectations, then a randomized requester/SPI-master soak.
module tb_spi_req_arbiter;

    localparam int N  = 3;
    localparam int W  = 16;
    localparam int TO = 64;
`ifdef SPI_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] txw = '0;
    logic           busy = 1'b0;
    logic           cpl = 1'b0;
    logic [W-1:0]   rxb = '0;
    logic [N-1:0]   grant, done;
    logic [W-1:0]   rx_word, tx_spi;
    logic           tmo_err, en;

    spi_req_arbiter #(.N_REQ(N), .DATA_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .req_tx_word_i(txw),
        .grant_o(grant), .req_done_o(done), .rx_word_o(rx_word),
        .timeout_err_o(tmo_err), .enable_spi_o(en), .tx_byte_spi_o(tx_spi),
        .busy_spi_i(busy), .complete_spi_i(cpl), .rx_byte_spi_i(rxb)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: who owns the master, whether this is its done cycle.
    int           m_owner = -1;
    bit           m_done = 1'b0;
    bit           m_tmo = 1'b0;
    int           m_rr = 0;
    int           m_cyc = 0;
    logic [W-1:0] m_tx = '0;
    logic [W-1:0] m_rx = '0;
    int           rand_dones = 0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_owner = -1; m_done = 0; m_tmo = 0; m_rr = 0; m_cyc = 0; m_tx = '0; m_rx = '0;
        end else if (m_done) begin
            m_done = 0; m_tmo = 0; m_owner = -1;
        end else if (m_owner < 0) begin
            if (req != '0 && !busy) begin
                for (int k = 0; k < N; k++) begin
                    if (m_owner < 0 && req[(m_rr + k) % N]) m_owner = (m_rr + k) % N;
                end
                m_tx  = txw[m_owner*W +: W];
                m_cyc = 0;
            end
        end else begin
            m_cyc++;
            if (cpl) begin
                m_rx = rxb; m_done = 1;
            end else if (TMO_EN && m_cyc == TO) begin
                m_done = 1; m_tmo = 1;
            end
            if (m_done) m_rr = (m_owner + 1) % N;
        end
    end

    bit rand_on = 1'b0;

    initial forever begin
        logic [N-1:0] eg, ed;
        @(posedge clk);
        #2;
        eg = '0;
        ed = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        if (m_done) ed = eg;
        check("grant", 32'(grant), 32'(eg));
        check("req_done", 32'(done), 32'(ed));
        check("enable_spi", 32'(en), 32'(m_owner >= 0 && !m_done));
        check("tx_byte_spi", 32'(tx_spi), 32'(m_tx));
        check("rx_word", 32'(rx_word), 32'(m_rx));
        check("timeout_err", 32'(tmo_err), 32'(m_tmo));
        if (rand_on && done != '0) rand_dones++;
    end

    // SPI master stand-in: completes a latched frame after a latency, pops rx words.
    bit           spi_active = 1'b0;
    bit           spi_hang = 1'b0;
    int           spi_cnt = 0;
    int           spi_lat = 20;
    logic [W-1:0] rx_q[$];

    initial forever begin
        @(negedge clk);
        cpl = 1'b0;
        if (!rst_n) begin
            spi_active = 1'b0;
        end else if (spi_active) begin
            spi_cnt--;
            if (spi_cnt <= 0) begin
                cpl = 1'b1;
                rxb = (rx_q.size() > 0) ? rx_q.pop_front() : W'($urandom);
                spi_active = 1'b0;
            end
        end else if (en && !spi_hang) begin
            spi_active = 1'b1;
            spi_cnt = rand_on ? int'($urandom_range(1, 8)) : spi_lat;
        end else if (rand_on && !en && $urandom_range(0, 99) < 5) begin
            cpl = 1'b1;
        end
        if (rand_on && !cpl) rxb = W'($urandom);
    end

    task automatic set_tx(input int i, input logic [W-1:0] v);
        txw[i*W +: W] = v;
    endtask

    task automatic wait_grant(input int lim, output logic [N-1:0] g, output int c);
        bit ok = 0;
        c = 0;
        while (!ok && c < lim) begin
            @(negedge clk);
            c++;
            if (grant != '0) ok = 1;
        end
        g = grant;
        check("wait_grant_bound", 32'(ok), 32'd1);
    endtask

    task automatic wait_done(input int lim, output logic [N-1:0] d, output int c);
        bit ok = 0;
        c = 0;
        while (!ok && c < lim) begin
            @(negedge clk);
            c++;
            if (done != '0) ok = 1;
        end
        d = done;
        check("wait_done_bound", 32'(ok), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; busy = 1'b0; spi_hang = 1'b0;
        rx_q.delete();
        repeat (3) @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rx", 32'(rx_word), 32'd0);
        check("rst_tx", 32'(tx_spi), 32'd0);
        check("rst_en", 32'(en), 32'd0);
        check("rst_tmo", 32'(tmo_err), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, got hang expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N-1:0] g, d;
        int c, extra;
        logic [W-1:0] exp_rx[4];
        exp_rx[0] = 16'hAA01; exp_rx[1] = 16'hBB02; exp_rx[2] = 16'hAA01; exp_rx[3] = 16'hBB02;

        // Single frame
        do_reset();
        set_tx(0, 16'h7425);
        rx_q.push_back(16'h0000);
        spi_lat = 20;
        req = 3'b001;
        wait_grant(5, g, c);
        check("t1_grant", 32'(g), 32'b001);
        check("t1_grant_lat", 32'(c), 32'd1);
        check("t1_tx", 32'(tx_spi), 32'h7425);
        check("t1_en", 32'(en), 32'd1);
        wait_done(40, d, c);
        check("t1_done", 32'(d), 32'b001);
        check("t1_done_lat", 32'(c), 32'd21);
        check("t1_rx", 32'(rx_word), 32'h0000);
        req = '0;
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (done != '0) extra++;
        end
        check("t1_single_done", 32'(extra), 32'd0);

        // Contention: rotating priority
        do_reset();
        set_tx(0, 16'h1111); set_tx(1, 16'h2222);
        for (int i = 0; i < 4; i++) rx_q.push_back(exp_rx[i]);
        spi_lat = 4;
        req = 3'b011;
        for (int f = 0; f < 4; f++) begin
            wait_grant(10, g, c);
            check("t2_grant", 32'(g), (f % 2 == 0) ? 32'b001 : 32'b010);
            if (f > 0) check("t2_regrant_gap", 32'(c), 32'd2);
            check("t2_tx", 32'(tx_spi), (f % 2 == 0) ? 32'h1111 : 32'h2222);
            wait_done(20, d, c);
            check("t2_done", 32'(d), 32'(g));
            check("t2_rx", 32'(rx_word), 32'(exp_rx[f]));
        end
        req = '0;

        // Owner withdraws mid-frame
        do_reset();
        spi_lat = 10;
        req = 3'b011;
        wait_grant(5, g, c);
        check("t3_grant0", 32'(g), 32'b001);
        repeat (3) @(negedge clk);
        req[0] = 1'b0;
        wait_done(20, d, c);
        check("t3_done0", 32'(d), 32'b001);
        wait_grant(5, g, c);
        check("t3_grant1", 32'(g), 32'b010);
        wait_done(20, d, c);
        req = '0;

        // Async reset mid-frame restores rr pointer
        do_reset();
        spi_lat = 4;
        req = 3'b001;
        wait_grant(5, g, c);
        wait_done(20, d, c);
        req = 3'b010;
        wait_grant(5, g, c);
        check("t4_grant1", 32'(g), 32'b010);
        repeat (5) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t4_rst_en", 32'(en), 32'd0);
        check("t4_rst_grant", 32'(grant), 32'd0);
        check("t4_rst_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        req = 3'b011;
        rst_n = 1'b1;
        wait_grant(5, g, c);
        check("t4_after_rst", 32'(g), 32'b001);
        wait_done(20, d, c);
        req = '0;

        // busy_spi blocks arbitration
        do_reset();
        busy = 1'b1;
        req = 3'b001;
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (grant != '0) extra++;
        end
        check("t5_blocked", 32'(extra), 32'd0);
        busy = 1'b0;
        @(negedge clk);
        check("t5_grant", 32'(grant), 32'b001);
        wait_done(20, d, c);
        req = '0;

        // Stuck master
        do_reset();
        rx_q.push_back(16'h1234);
        req = 3'b001;
        wait_grant(5, g, c);
        wait_done(20, d, c);
        req = '0;
        check("t6_rx_pre", 32'(rx_word), 32'h1234);
        spi_hang = 1'b1;
        @(negedge clk);
        req = 3'b100;
        wait_grant(5, g, c);
        check("t6_grant", 32'(g), 32'b100);
`ifdef SPI_ARB_TIMEOUT_EN
        wait_done(100, d, c);
        check("t6_tmo_lat", 32'(c), 32'd64);
        check("t6_done", 32'(d), 32'b100);
        check("t6_tmo", 32'(tmo_err), 32'd1);
        check("t6_rx_kept", 32'(rx_word), 32'h1234);
        @(negedge clk);
        check("t6_tmo_pulse", 32'(tmo_err), 32'd0);
`else
        extra = 0;
        repeat (200) begin
            @(negedge clk);
            if (done != '0 || !en) extra++;
        end
        check("t6_waits_forever", 32'(extra), 32'd0);
`endif
        req = '0;

        // Randomized soak
        do_reset();
        rand_on = 1'b1;
        repeat (3000) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (req[i] && (done[i] || $urandom_range(0, 99) < 2)) begin
                    req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 99) < 30) begin
                    req[i] = 1'b1;
                    set_tx(i, W'($urandom));
                end
            end
            busy = ($urandom_range(0, 99) < 10);
        end
        req = '0;
        busy = 1'b0;
        rand_on = 1'b0;
        repeat (20) @(negedge clk);
        check("rand_activity", 32'(rand_dones > 100), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
